// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the PC and runs one outstanding imem request at a time.
// Fills the IF/ID slot and applies decode redirects while keeping the delay slot.
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        exc_misalign
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic        if_valid_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_pc4_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic        redir_pend_q;
  logic [31:0] redir_tgt_q;
  logic        exc_q;

  logic   redir_misalign;
  logic   redir_at_ds;
  logic   kill_req;
  logic   grant;
  logic   resp;
  logic   slot_free;
  state_e resume_state;

  // The branch sits in IF/ID, so its delay slot address is if_pc4.
  assign redir_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redir_at_ds    = (pc_q == if_pc4_q);
  // pc already points past the delay slot: suppress the wrong-path request.
  assign kill_req       = redirect_valid && (redir_misalign || !redir_at_ds);

  assign imem_req     = (state_q == StReq) && !kill_req;
  assign imem_addr    = pc_q;
  assign grant        = imem_req && imem_gnt;
  assign resp         = (state_q == StWait) && imem_rvalid;
  assign slot_free    = !if_valid_q || !stall_d;
  assign resume_state = (exc_q || redir_misalign) ? StHalt : StReq;

  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;
  assign if_pc4       = if_pc4_q;
  assign exc_misalign = exc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      req_addr_q   <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      if_pc4_q     <= 32'd4;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
      exc_q        <= 1'b0;
    end else begin
      // PC and pending-redirect bookkeeping
      if (grant) begin
        req_addr_q   <= pc_q;
        redir_pend_q <= 1'b0;
        if (redirect_valid) begin
          pc_q <= redirect_pc;
        end else if (redir_pend_q) begin
          pc_q <= redir_tgt_q;
        end else begin
          pc_q <= pc_q + 32'd4;
        end
      end else if (redirect_valid && !redir_misalign) begin
        if (redir_at_ds) begin
          redir_pend_q <= 1'b1;
          redir_tgt_q  <= redirect_pc;
        end else begin
          pc_q <= redirect_pc;
        end
      end

      if (redir_misalign) begin
        exc_q <= 1'b1;
      end

      // IF/ID slot: response, skid move, or drain
      if (resp && slot_free) begin
        if_valid_q <= 1'b1;
        if_instr_q <= imem_rdata;
        if_pc_q    <= req_addr_q;
        if_pc4_q   <= req_addr_q + 32'd4;
      end else if ((state_q == StHold) && !stall_d) begin
        if_valid_q <= 1'b1;
        if_instr_q <= skid_instr_q;
        if_pc_q    <= skid_pc_q;
        if_pc4_q   <= skid_pc_q + 32'd4;
      end else if (!stall_d) begin
        if_valid_q <= 1'b0;
      end

      if (resp && !slot_free) begin
        skid_instr_q <= imem_rdata;
        skid_pc_q    <= req_addr_q;
      end

      unique case (state_q)
        StReq: begin
          if (redir_misalign) begin
            state_q <= StHalt;
          end else if (grant) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (resp) begin
            state_q <= slot_free ? resume_state : StHold;
          end
        end
        StHold: begin
          if (!stall_d) begin
            state_q <= resume_state;
          end
        end
        StHalt: state_q <= StHalt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Cycle-table bench for fetch_seq_ctrl with an in-order scoreboard on IF/ID deliveries.
module tb_fetch_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_d = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        exc_misalign;

  fetch_seq_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .stall_d        (stall_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .exc_misalign   (exc_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r;   // hold reset low
    bit          s;   // stall_d
    bit          g;   // imem_gnt
    bit          v;   // imem_rvalid
    bit          p;   // response is expected to be accepted
    logic [31:0] a;   // address the response belongs to
    bit          rd;  // redirect_valid
    logic [31:0] rp;  // redirect_pc
    bit          er;  // expected imem_req
    logic [31:0] ea;  // expected imem_addr
    bit          ev;  // expected if_valid
    bit          ex;  // expected exc_misalign
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  logic [31:0] cur_pc;
  bit          prev_ev;
  bit          prev_s;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic vec_t row(input bit r, s, g, v, p, input logic [31:0] a, input bit rd,
                               input logic [31:0] rp, input bit er, input logic [31:0] ea,
                               input bit ev, ex);
    vec_t t;
    t.r = r; t.s = s; t.g = g; t.v = v; t.p = p; t.a = a; t.rd = rd; t.rp = rp;
    t.er = er; t.ea = ea; t.ev = ev; t.ex = ex;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, s, g, v, input logic [31:0] a, input bit rd,
                       input logic [31:0] rp);
    rst_n          = !r;
    stall_d        = s;
    imem_gnt       = g;
    imem_rvalid    = v;
    imem_rdata     = word(a);
    redirect_valid = rd;
    redirect_pc    = rp;
  endtask

  localparam logic [31:0] X = 32'h0;
  localparam logic [31:0] R = 32'h3000;

  initial begin
    // r s g v p a          rd rp             er ea              ev ex
    // Basic streaming: grant immediate, rvalid one cycle later
    vecs.push_back(row(1,0,0,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,0,1,1,R,          0,X,             0,32'h3004,      0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,32'h3004,      1,0));
    vecs.push_back(row(0,0,0,1,1,32'h3004,   0,X,             0,32'h3008,      0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,32'h3008,      1,0));
    vecs.push_back(row(0,0,0,1,1,32'h3008,   0,X,             0,32'h300C,      0,0));
    vecs.push_back(row(0,0,0,0,0,X,          0,X,             1,32'h300C,      1,0));
    // Stall with response arriving: skid, hold, release
    vecs.push_back(row(1,0,0,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,0,1,1,R,          0,X,             0,32'h3004,      0,0));
    vecs.push_back(row(0,1,1,0,0,X,          0,X,             1,32'h3004,      1,0));
    vecs.push_back(row(0,1,0,1,1,32'h3004,   0,X,             0,32'h3008,      1,0));
    vecs.push_back(row(0,1,0,0,0,X,          0,X,             0,32'h3008,      1,0));
    vecs.push_back(row(0,1,1,0,0,X,          0,X,             0,32'h3008,      1,0));
    vecs.push_back(row(0,1,0,0,0,X,          0,X,             0,32'h3008,      1,0));
    vecs.push_back(row(0,0,0,0,0,X,          0,X,             0,32'h3008,      1,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,32'h3008,      1,0));
    vecs.push_back(row(0,0,0,1,1,32'h3008,   0,X,             0,32'h300C,      0,0));
    vecs.push_back(row(0,0,0,0,0,X,          0,X,             1,32'h300C,      1,0));
    // Redirect before delay slot grant (pending), then redirect on the DS grant cycle
    vecs.push_back(row(1,0,0,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,0,1,1,R,          0,X,             0,32'h3004,      0,0));
    vecs.push_back(row(0,0,0,0,0,X,          1,32'h3100,      1,32'h3004,      1,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,32'h3004,      0,0));
    vecs.push_back(row(0,0,0,1,1,32'h3004,   0,X,             0,32'h3100,      0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,32'h3100,      1,0));
    vecs.push_back(row(0,0,0,1,1,32'h3100,   0,X,             0,32'h3104,      0,0));
    vecs.push_back(row(0,0,1,0,0,X,          1,32'h3300,      1,32'h3104,      1,0));
    vecs.push_back(row(0,0,0,1,1,32'h3104,   0,X,             0,32'h3300,      0,0));
    vecs.push_back(row(0,0,0,0,0,X,          0,X,             1,32'h3300,      1,0));
    // Redirect after delay slot granted: wrong path suppressed, gnt=1 ignored
    vecs.push_back(row(1,0,0,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,0,1,1,R,          0,X,             0,32'h3004,      0,0));
    vecs.push_back(row(0,1,1,0,0,X,          0,X,             1,32'h3004,      1,0));
    vecs.push_back(row(0,0,1,0,0,X,          1,32'h3200,      0,32'h3008,      1,0));
    vecs.push_back(row(0,0,0,1,1,32'h3004,   0,X,             0,32'h3200,      0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,32'h3200,      1,0));
    vecs.push_back(row(0,0,0,1,1,32'h3200,   0,X,             0,32'h3204,      0,0));
    vecs.push_back(row(0,0,0,0,0,X,          0,X,             1,32'h3204,      1,0));
    // Misaligned target: exception, halt, in-flight instruction still delivered
    vecs.push_back(row(1,0,0,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,0,1,1,R,          0,X,             0,32'h3004,      0,0));
    vecs.push_back(row(0,1,1,0,0,X,          0,X,             1,32'h3004,      1,0));
    vecs.push_back(row(0,0,0,0,0,X,          1,32'h3102,      0,32'h3008,      1,0));
    vecs.push_back(row(0,0,0,1,1,32'h3004,   0,X,             0,32'h3008,      0,1));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             0,32'h3008,      1,1));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             0,32'h3008,      0,1));
    vecs.push_back(row(0,0,0,1,0,32'h3008,   0,X,             0,32'h3008,      0,1));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             0,32'h3008,      0,1));
    // Reset while waiting; stale response afterwards is ignored
    vecs.push_back(row(1,0,0,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(1,0,0,1,0,R,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,0,1,0,R,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,0,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,0,1,1,R,          0,X,             0,32'h3004,      0,0));
    vecs.push_back(row(0,0,0,0,0,X,          0,X,             1,32'h3004,      1,0));
    // PC wrap past 0xFFFF_FFFC
    vecs.push_back(row(1,0,0,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,R,             0,0));
    vecs.push_back(row(0,0,0,1,1,R,          0,X,             0,32'h3004,      0,0));
    vecs.push_back(row(0,0,1,0,0,X,          1,32'hFFFF_FFFC, 1,32'h3004,      1,0));
    vecs.push_back(row(0,0,0,1,1,32'h3004,   0,X,             0,32'hFFFF_FFFC, 0,0));
    vecs.push_back(row(0,0,1,0,0,X,          0,X,             1,32'hFFFF_FFFC, 1,0));
    vecs.push_back(row(0,0,0,1,1,32'hFFFF_FFFC,0,X,           0,32'h0,         0,0));
    vecs.push_back(row(0,0,0,0,0,X,          0,X,             1,32'h0,         1,0));

    prev_ev = 1'b0;
    prev_s  = 1'b0;
    cur_pc  = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t t;
      t = vecs[i];
      @(negedge clk);
      drive(t.r, t.s, t.g, t.v, t.a, t.rd, t.rp);
      #1;
      chk($sformatf("imem_req[%0d]", i), {31'b0, imem_req}, {31'b0, t.er});
      chk($sformatf("imem_addr[%0d]", i), imem_addr, t.ea);
      chk($sformatf("if_valid[%0d]", i), {31'b0, if_valid}, {31'b0, t.ev});
      chk($sformatf("exc_misalign[%0d]", i), {31'b0, exc_misalign}, {31'b0, t.ex});
      if (t.r) begin
        chk($sformatf("rst_if_pc[%0d]", i), if_pc, 32'h0);
        chk($sformatf("rst_if_pc4[%0d]", i), if_pc4, 32'h4);
        chk($sformatf("rst_if_instr[%0d]", i), if_instr, 32'h0);
      end else if (t.ev) begin
        if (!prev_ev || !prev_s) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty[%0d]: got delivery of %h want none", i, if_pc);
          end else begin
            cur_pc = sb.pop_front();
            chk($sformatf("if_pc[%0d]", i), if_pc, cur_pc);
            chk($sformatf("if_instr[%0d]", i), if_instr, word(cur_pc));
            chk($sformatf("if_pc4[%0d]", i), if_pc4, cur_pc + 32'd4);
          end
        end else begin
          chk($sformatf("held_pc[%0d]", i), if_pc, cur_pc);
          chk($sformatf("held_instr[%0d]", i), if_instr, word(cur_pc));
        end
      end
      if (t.p) sb.push_back(t.a);
      prev_ev = t.ev && !t.r;
      prev_s  = t.s;
    end
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    // Reset must clear the slot asynchronously, between clock edges
    drive(1, 0, 0, 0, X, 0, X);
    @(negedge clk);
    drive(0, 0, 1, 0, X, 0, X);
    @(negedge clk);
    drive(0, 0, 0, 1, R, 0, X);
    @(negedge clk);
    drive(0, 1, 0, 0, X, 0, X);
    #1;
    chk("async_pre_valid", {31'b0, if_valid}, 32'd1);
    chk("async_pre_pc", if_pc, R);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, if_valid}, 32'd0);
    chk("async_pc", if_pc, 32'h0);
    chk("async_instr", if_instr, 32'h0);
    chk("async_pc4", if_pc4, 32'h4);
    chk("async_addr", imem_addr, R);
    chk("async_req", {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, X, 0, X);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_seq_ctrl.md
# fetch_seq_ctrl

Fetch sequencer for the MIPS pipeline. It owns the PC register and issues instruction-memory requests over a request/grant + response handshake, with one request outstanding at a time. It feeds the IF/ID register (instruction, PC, PC+4; PC+4 drives the next-PC calculator in decode). It applies taken branch/jump redirects from decode while honouring the architectural branch delay slot.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; equals internal pc.
- imem_gnt  in  1  request accepted this cycle (counts only when imem_req=1).
- imem_rvalid  in  1  response valid; at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- stall_d  in  1  IF/ID hold from the hazard unit.
- redirect_valid  in  1  one-cycle pulse: branch/jump in decode is taken. Only asserted with stall_d=0.
- redirect_pc  in  32  target from the next-PC calculator.
- if_valid  out  1  IF/ID contents valid.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- if_pc4  out  32  if_pc+4, mod 2^32.
- exc_misalign  out  1  sticky: redirect target not word-aligned.

## Operation
- Registers: pc, req_addr (address of the outstanding request), output slot (if_*), one-entry skid buffer (instr+pc), redir_pend, redir_tgt, exc flag.
- FSM states:
  - S_REQ: imem_req=1. On a grant, req_addr<=pc and pc<=pc+4 (or redirect, below); then S_WAIT.
  - S_WAIT: imem_req=0. On rvalid:
    - If the slot is free (if_valid=0 or stall_d=0), write it; then S_REQ.
    - Otherwise write the skid buffer; then S_HOLD.
  - S_HOLD: imem_req=0. When stall_d=0, move skid to slot; then S_REQ.
  - S_HALT: imem_req=0 forever. The slot still drains normally.
- Slot drain: if stall_d=0 and nothing is written this cycle, if_valid<=0. If stall_d=1, the slot holds.
- Redirect, with B = if_pc of the branch and delay slot address DS = B+4:
  - If pc==DS (delay slot not yet granted): set redir_pend and redir_tgt<=redirect_pc. At the delay slot's grant, pc<=redir_tgt instead of pc+4, and clear redir_pend. If that grant happens in the redirect cycle itself, apply the target directly.
  - Otherwise the delay slot is already granted or buffered, and pc==B+8 is wrong-path. Force imem_req=0 combinationally this cycle, so no B+8 grant occurs, and set pc<=redirect_pc.
  - The delay-slot instruction is never discarded.
- Misalignment: if redirect_pc[1:0]!=0, set exc_misalign and go to S_HALT. No request to that target is issued. The outstanding response is still accepted.
- pc+4 wraps mod 2^32 with no flag.

## Timing
- Reset values:
  - state=S_REQ, pc=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=0, if_pc4=4, exc_misalign=0.
  - Skid empty, redir_pend=0.
- imem_req=1 in the first cycle after rst_n deasserts.
- Grant at cycle t gives S_WAIT at t+1. Response at t+k (k≥1) gives if_valid=1 at t+k+1, provided the slot is free.
- Peak throughput: one instruction per 2 cycles with k=1.
- rvalid outside S_WAIT is ignored.
- Reset asserted mid-transaction: all state clears immediately. A response arriving after reset, before any new grant, is ignored.
- Simultaneous rvalid with stall_d=1 and if_valid=1: the response goes to skid, and the slot is unchanged.
- Simultaneous redirect and rvalid: both take effect; pc follows the redirect rules.

## Test plan
- Reset, no stalls, gnt immediate, rvalid 1 cycle later. Required: imem_addr sequence 0x3000, 0x3004, 0x3008; if_pc follows one per 2 cycles; if_pc4=0x3004 when if_pc=0x3000.
- stall_d=1 for 5 cycles while if_valid=1 and a response arrives. Required: state S_HOLD, imem_req=0, slot unchanged. On stall release the skid word appears next cycle, then fetch resumes at the next sequential pc.
- Branch at 0x3000 redirects to 0x3100 while pc==0x3004 (delay slot not yet granted). Required: fetch order 0x3004, then 0x3100; no fetch of 0x3008.
- Redirect to 0x3200 when pc==0x3008 and gnt=1 that cycle. Required: imem_req=0 that cycle, next request address 0x3200, delay slot 0x3004 delivered.
- redirect_pc=0x3102. Required: exc_misalign=1 next cycle, state S_HALT, imem_req stays 0, the in-flight instruction still delivered.
- rst_n pulsed low while in S_WAIT. Required: outputs at reset values, first request address 0x3000, stale rvalid ignored.
